// File: rtl/pipemem.sv
// pipemem: MEM stage data memory (64 x 32) plus MEM/WB pipeline register.
// Latency: mmo is combinational (0 cycles); all W-stage outputs are 1 cycle.
// Backpressure: none; one instruction accepted every cycle. Optional macro: DMEM_ALIGN_CHECK_EN.
module pipemem (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic [31:0] mmo,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        dfault,
    output logic [31:0] dfaddr
);

    // Word storage; deliberately not reset so contents survive resetn.
    logic [31:0] mem_q [64];

    // Only bits [7:2] select a word, so the 256-byte window aliases upward.
    logic [5:0]  idx;
    logic        misaligned;
    logic        mem_we;

    logic        wwreg_q,  wwreg_d;
    logic        wm2reg_q, wm2reg_d;
    logic [31:0] wmo_q,    wmo_d;
    logic [31:0] walu_q,   walu_d;
    logic [4:0]  wrn_q,    wrn_d;

    assign idx = malu[7:2];

    // Read port is asynchronous so the forwarding path sees the data this cycle.
    assign mmo = mem_q[idx];

`ifdef DMEM_ALIGN_CHECK_EN
    logic        dfault_q,  dfault_d;
    logic [31:0] dfaddr_q,  dfaddr_d;

    // Any load or store whose byte offset is non-zero is flagged.
    assign misaligned = (mwmem | mm2reg) & (malu[1:0] != 2'b00);

    // Sticky fault flag; the address is latched only on the first fault.
    always_comb begin
        dfault_d = dfault_q;
        dfaddr_d = dfaddr_q;
        if (misaligned && !dfault_q) begin
            dfault_d = 1'b1;
            dfaddr_d = malu;
        end
    end

    // Fault state, cleared only by reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dfault_q <= 1'b0;
            dfaddr_q <= 32'h0;
        end else begin
            dfault_q <= dfault_d;
            dfaddr_q <= dfaddr_d;
        end
    end

    assign dfault = dfault_q;
    assign dfaddr = dfaddr_q;
`else
    // Offset bits are don't-care; nothing is ever suppressed.
    assign misaligned = 1'b0;
    assign dfault     = 1'b0;
    assign dfaddr     = 32'h0;
`endif

    // A misaligned store is dropped so memory is never partially corrupted.
    assign mem_we = mwmem & ~misaligned;

    // Write port; reset only gates writes, it never clears contents.
    always_ff @(posedge clock) begin
        if (resetn && mem_we) begin
            mem_q[idx] <= mb;
        end
    end

    // Next-state for MEM/WB; a faulting load must not write the register file.
    always_comb begin
        wwreg_d  = mwreg & ~(mm2reg & misaligned);
        wm2reg_d = mm2reg;
        wmo_d    = mmo;
        walu_d   = malu;
        wrn_d    = mrn;
    end

    // MEM/WB pipeline register; wmo captures pre-write data on a same-index store.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wmo_q    <= 32'h0;
            walu_q   <= 32'h0;
            wrn_q    <= 5'h0;
        end else begin
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wmo_q    <= wmo_d;
            walu_q   <= walu_d;
            wrn_q    <= wrn_d;
        end
    end

    assign wwreg  = wwreg_q;
    assign wm2reg = wm2reg_q;
    assign wmo    = wmo_q;
    assign walu   = walu_q;
    assign wrn    = wrn_q;

endmodule

// File: doc/pipemem.md
PIPEMEM -- requirements
Module: pipemem

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning), clock and reset first:
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 mwreg, mm2reg, mwmem  input  1 each  MEM-stage register-write, load-select and store-enable controls from the EX/MEM register.
REQ-005 malu  input  32  MEM-stage ALU result, used as the byte address for loads and stores.
REQ-006 mb  input  32  MEM-stage store data.
REQ-007 mrn  input  5  MEM-stage destination register number.
REQ-008 mmo  output  32  combinational data-memory read data, used for forwarding.
REQ-009 wwreg, wm2reg  output  1 each  WB-stage controls, registered.
REQ-010 wmo, walu  output  32 each  WB-stage load data and ALU result, registered.
REQ-011 wrn  output  5  WB-stage destination register number, registered.
REQ-012 dfault  output  1  sticky misaligned-access flag (see Configuration).
REQ-013 dfaddr  output  32  address of the first faulting access (see Configuration).

Function
REQ-014 Data memory SHALL be 64 x 32-bit words, indexed by malu[7:2]; malu[31:8] are ignored, so addresses alias every 256 bytes.
REQ-015 mmo SHALL equal mem[malu[7:2]] combinationally, with zero added latency.
REQ-016 When mwmem=1, resetn=1 and the access is not suppressed, mem[malu[7:2]] SHALL take the value of mb on the rising clock edge.
REQ-017 The MEM/WB register SHALL capture mwreg, mm2reg, mmo, malu and mrn into wwreg, wm2reg, wmo, walu and wrn on every rising edge, giving one cycle of latency.
REQ-018 On a store and read to the same index in the same cycle, mmo and the captured wmo SHALL hold the pre-write data.
REQ-019 There SHALL be no stall or flush input; one instruction SHALL be accepted per cycle, every cycle.

Reset
REQ-020 Asserting resetn=0 SHALL immediately clear wwreg, wm2reg, wmo, walu, wrn, dfault and dfaddr to 0, regardless of the clock.
REQ-021 While resetn=0, memory writes SHALL be blocked.
REQ-022 Memory contents SHALL NOT be affected by reset; a word's content is undefined until it is first written.
REQ-023 Registered outputs SHALL resume tracking their inputs on the first rising edge after resetn returns to 1.

Configuration
REQ-024 The block SHALL provide the macro DMEM_ALIGN_CHECK_EN to compile the alignment check in or out.
REQ-025 With DMEM_ALIGN_CHECK_EN defined, an access SHALL be misaligned when (mwmem or mm2reg)=1 and malu[1:0] is not 0.
REQ-026 With DMEM_ALIGN_CHECK_EN defined, a misaligned store SHALL leave memory unchanged.
REQ-027 With DMEM_ALIGN_CHECK_EN defined, a misaligned load SHALL capture wwreg as 0 at the next edge.
REQ-028 With DMEM_ALIGN_CHECK_EN defined, dfault SHALL set to 1 at the edge of the first misaligned access and stay 1 until reset.
REQ-029 With DMEM_ALIGN_CHECK_EN defined, dfaddr SHALL capture malu only at the edge where dfault goes 0->1.
REQ-030 Without DMEM_ALIGN_CHECK_EN, malu[1:0] SHALL be ignored, no access SHALL be suppressed, and dfault and dfaddr SHALL be constant 0.

Verification
REQ-031 Store then load: mwmem=1, malu=0x10, mb=0xDEADBEEF; next cycle mm2reg=1, mwreg=1, malu=0x10, mrn=5 -> mmo=0xDEADBEEF immediately; one edge later wmo=0xDEADBEEF, wwreg=1, wrn=5.
REQ-032 Aliasing: store 0x12345678 at malu=0x104, then read malu=0x004 -> mmo=0x12345678.
REQ-033 Pass-through: mwreg=1, mm2reg=0, malu=0xA5A5A5A5, mrn=31 -> after one edge walu=0xA5A5A5A5, wwreg=1, wm2reg=0, wrn=31.
REQ-034 Async reset: drive resetn=0 between clock edges while wwreg=1 -> wwreg, walu, wrn and dfault read 0 before the next edge; a memory word written before reset reads back unchanged after reset.
REQ-035 With DMEM_ALIGN_CHECK_EN: store mb=0x1 at malu=0x22 onto a word holding 0x0 -> word stays 0x0, dfault=1, dfaddr=0x22; a later misaligned load at malu=0x33 -> wwreg=0 and dfaddr stays 0x22.
REQ-036 Without DMEM_ALIGN_CHECK_EN: store 0x77 at malu=0x23 -> a read at malu=0x20 returns 0x77, and dfault stays 0.
